// File: rtl/tick_meter.sv
// Period meter for an asynchronous tick input: synchronizes sig_in, measures clk_in cycles
// between rising edges, averages 2^AVG_LOG2 periods and hands results out over valid/ready.
module tick_meter #(
    parameter int CNT_W         = 32,
    parameter int TIMEOUT_TICKS = 1000000,
    parameter int AVG_LOG2      = 0
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             enable,
    input  logic             ready,
    output logic             valid,
    output logic [CNT_W-1:0] period,
    output logic             timeout,
    output logic             overrun
);

    localparam int               ACC_W = CNT_W + AVG_LOG2;
    localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT_TICKS);
    localparam logic [4:0]       NSAMP = 5'(1 << AVG_LOG2);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync3;
    logic               r_edge;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [4:0]         r_samp;
    logic               r_valid;
    logic [CNT_W-1:0]   r_period;
    logic               r_timeout;
    logic               r_overrun;

    logic               w_tmo;
    logic               w_meas_edge;
    logic [ACC_W-1:0]   w_sum;
    logic [4:0]         w_samp_inc;
    logic               w_done;
    logic               w_load;
    logic [CNT_W-1:0]   w_result;

    // Two synchronizer flops, then a registered rising-edge detector (pulse 3 cycles after sig_in rises)
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_edge  <= r_sync2 & ~r_sync3;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (enable) w_next = ARM;
            ARM: begin
                if (!enable)     w_next = IDLE;
                else if (r_edge) w_next = MEASURE;
            end
            MEASURE: begin
                if (!enable)     w_next = IDLE;
                else if (w_tmo)  w_next = ARM;
            end
            default:             w_next = IDLE;
        endcase
    end

    // An edge in the same cycle as the timeout count always wins
    always_comb begin
        w_tmo       = enable && (r_state != IDLE) && !r_edge && (r_cnt == TMO);
        w_meas_edge = enable && (r_state == MEASURE) && r_edge;
        w_sum       = r_acc + ACC_W'(r_cnt);
        w_samp_inc  = r_samp + 5'd1;
        w_done      = w_meas_edge && (w_samp_inc == NSAMP);
        w_load      = w_done || w_tmo;
        w_result    = w_tmo ? '0 : CNT_W'(w_sum >> AVG_LOG2);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_samp <= '0;
        end else if (!enable || r_state == IDLE) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_samp <= '0;
        end else if (r_edge) begin
            r_cnt <= CNT_W'(1);
            if (w_meas_edge && !w_done) begin
                r_acc  <= w_sum;
                r_samp <= w_samp_inc;
            end else begin
                r_acc  <= '0;
                r_samp <= '0;
            end
        end else if (w_tmo) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_samp <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A load into an unaccepted result marks overrun; a handshake consumes the result
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_period  <= '0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_period  <= w_result;
            r_timeout <= w_tmo;
            if (r_valid && !ready)     r_overrun <= 1'b1;
            else if (r_valid && ready) r_overrun <= 1'b0;
        end else if (r_valid && ready) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign valid   = r_valid;
    assign period  = r_period;
    assign timeout = r_timeout;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_tick_meter.sv
// Self-checking bench for tick_meter: table of edge spacings with expected results,
// plus directed sequences for overrun, enable drop, ARM timeout, reset and averaging.
module tb_tick_meter;

    typedef struct {
        int          gap;
        logic [31:0] expPeriod;
        logic        expTimeout;
    } vec_t;

    typedef struct {
        logic [31:0] p;
        logic        t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        sigIn, enable, ready;
    logic        valid, timeout, overrun;
    logic [31:0] period;
    logic        sigIn1, enable1, ready1;
    logic        valid1, timeout1, overrun1;
    logic [31:0] period1;

    int          nChecks = 0;
    int          nFail = 0;
    logic        monOn = 1'b0;
    exp_t        expQ[$];
    exp_t        monExp;
    logic [31:0] got1[$];
    int          tmoCount1 = 0;
    vec_t        vecs[11];

    always #10 clk = ~clk;

    tick_meter #(.CNT_W(32), .TIMEOUT_TICKS(1000), .AVG_LOG2(0)) dut0 (
        .clk_in(clk), .rst_n(rstN), .sig_in(sigIn), .enable(enable), .ready(ready),
        .valid(valid), .period(period), .timeout(timeout), .overrun(overrun)
    );

    tick_meter #(.CNT_W(32), .TIMEOUT_TICKS(1000), .AVG_LOG2(2)) dut1 (
        .clk_in(clk), .rst_n(rstN), .sig_in(sigIn1), .enable(enable1), .ready(ready1),
        .valid(valid1), .period(period1), .timeout(timeout1), .overrun(overrun1)
    );

    function automatic void checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendRise();
        sigIn = 1'b1;
        tick();
        sigIn = 1'b0;
    endtask

    task automatic sendRise1();
        sigIn1 = 1'b1;
        tick();
        sigIn1 = 1'b0;
    endtask

    task automatic waitValid(input int limit, output int n);
        n = 0;
        while (!valid && n < limit) begin
            tick();
            n++;
        end
        if (!valid) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL waitValid: valid=%0d after %0d cycles, expected 1", valid, n);
        end
    endtask

    // Pushes each vector's expected result, then spaces the next sig_in rise by gap cycles
    task automatic applyStimulus();
        sendRise();
        for (int i = 0; i < 11; i++) begin
            expQ.push_back('{p: vecs[i].expPeriod, t: vecs[i].expTimeout});
            repeat (vecs[i].gap - 1) tick();
            sendRise();
        end
        repeat (8) tick();
        checkOutput("tableDrained", 64'(expQ.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (monOn && valid && ready) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFail++;
                $display("[TB] FAIL unexpectedResult: got period %0d timeout %0d, expected none", period, timeout);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("tablePeriod", 64'(period), 64'(monExp.p));
                checkOutput("tableTimeout", 64'(timeout), 64'(monExp.t));
            end
        end
        if (valid1 && ready1) begin
            got1.push_back(period1);
            if (timeout1) tmoCount1++;
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        vecs[0]  = '{gap: 10,   expPeriod: 32'd10,   expTimeout: 1'b0};
        vecs[1]  = '{gap: 10,   expPeriod: 32'd10,   expTimeout: 1'b0};
        vecs[2]  = '{gap: 7,    expPeriod: 32'd7,    expTimeout: 1'b0};
        vecs[3]  = '{gap: 2,    expPeriod: 32'd2,    expTimeout: 1'b0};
        vecs[4]  = '{gap: 25,   expPeriod: 32'd25,   expTimeout: 1'b0};
        vecs[5]  = '{gap: 1000, expPeriod: 32'd1000, expTimeout: 1'b0};
        vecs[6]  = '{gap: 999,  expPeriod: 32'd999,  expTimeout: 1'b0};
        vecs[7]  = '{gap: 1001, expPeriod: 32'd0,    expTimeout: 1'b1};
        vecs[8]  = '{gap: 10,   expPeriod: 32'd10,   expTimeout: 1'b0};
        vecs[9]  = '{gap: 1200, expPeriod: 32'd0,    expTimeout: 1'b1};
        vecs[10] = '{gap: 13,   expPeriod: 32'd13,   expTimeout: 1'b0};

        rstN = 1'b0; sigIn = 1'b0; enable = 1'b0; ready = 1'b1;
        sigIn1 = 1'b0; enable1 = 1'b0; ready1 = 1'b1;
        repeat (3) tick();
        checkOutput("resetValid", 64'(valid), 64'd0);
        checkOutput("resetPeriod", 64'(period), 64'd0);
        checkOutput("resetTimeout", 64'(timeout), 64'd0);
        checkOutput("resetOverrun", 64'(overrun), 64'd0);
        rstN = 1'b1;
        tick();

        enable = 1'b1;
        monOn = 1'b1;
        tick();
        applyStimulus();
        monOn = 1'b0;

        // Two results without acceptance: second overwrites first
        enable = 1'b0; ready = 1'b0;
        repeat (2) tick();
        enable = 1'b1;
        tick();
        sendRise();
        repeat (9) tick();
        sendRise();
        repeat (5) tick();
        checkOutput("firstValid", 64'(valid), 64'd1);
        checkOutput("firstPeriod", 64'(period), 64'd10);
        checkOutput("firstOverrun", 64'(overrun), 64'd0);
        sendRise();
        repeat (6) tick();
        checkOutput("ovwValid", 64'(valid), 64'd1);
        checkOutput("ovwPeriod", 64'(period), 64'd6);
        checkOutput("ovwTimeout", 64'(timeout), 64'd0);
        checkOutput("ovwOverrun", 64'(overrun), 64'd1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checkOutput("hsValid", 64'(valid), 64'd0);
        checkOutput("hsOverrun", 64'(overrun), 64'd0);

        // Enable drop keeps the held result and ignores further edges
        enable = 1'b0;
        repeat (2) tick();
        enable = 1'b1;
        tick();
        sendRise();
        repeat (11) tick();
        sendRise();
        repeat (6) tick();
        checkOutput("enPeriod", 64'(period), 64'd12);
        enable = 1'b0;
        repeat (3) tick();
        sendRise();
        repeat (7) tick();
        sendRise();
        repeat (6) tick();
        checkOutput("enHeldValid", 64'(valid), 64'd1);
        checkOutput("enHeldPeriod", 64'(period), 64'd12);
        checkOutput("enHeldOverrun", 64'(overrun), 64'd0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checkOutput("enConsumed", 64'(valid), 64'd0);

        // No edges at all: ARM times out after TIMEOUT_TICKS
        enable = 1'b1;
        waitValid(1100, n);
        checkOutput("armTmoLatency", 64'(n), 64'd1002);
        checkOutput("armTmoPeriod", 64'(period), 64'd0);
        checkOutput("armTmoFlag", 64'(timeout), 64'd1);
        ready = 1'b1;
        tick();
        ready = 1'b0;

        // Asynchronous reset mid-measurement, then re-arm required
        sendRise();
        repeat (7) tick();
        sendRise();
        repeat (6) tick();
        checkOutput("preRstPeriod", 64'(period), 64'd8);
        repeat (3) tick();
        #4 rstN = 1'b0;
        #1;
        checkOutput("rstValid", 64'(valid), 64'd0);
        checkOutput("rstPeriod", 64'(period), 64'd0);
        checkOutput("rstTimeout", 64'(timeout), 64'd0);
        checkOutput("rstOverrun", 64'(overrun), 64'd0);
        tick();
        tick();
        rstN = 1'b1;
        tick();
        sendRise();
        repeat (9) tick();
        checkOutput("rearmNoResult", 64'(valid), 64'd0);
        sendRise();
        waitValid(20, n);
        checkOutput("rearmPeriod", 64'(period), 64'd10);
        checkOutput("rearmTimeout", 64'(timeout), 64'd0);
        ready = 1'b1;
        tick();
        enable = 1'b0;
        tick();

        // Averaging over four periods, including truncation of 43/4
        enable1 = 1'b1;
        tick();
        sendRise1();
        foreach (vecs[i]) begin
            if (i < 8) begin
                repeat ((i == 7) ? 12 : ((i >= 4) ? 9 : ((i % 2 == 0) ? 8 : 10))) tick();
                sendRise1();
            end
        end
        repeat (8) tick();
        enable1 = 1'b0;
        checkOutput("avgCount", 64'(got1.size()), 64'd2);
        if (got1.size() >= 1) checkOutput("avgFirst", 64'(got1[0]), 64'd10);
        if (got1.size() >= 2) checkOutput("avgSecond", 64'(got1[1]), 64'd10);
        checkOutput("avgTimeouts", 64'(tmoCount1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/tick_meter.md
TICK_METER -- requirements
Module: tick_meter

Interface
REQ-001 Parameter CNT_W, default 32, width of period counter, accumulator result and period output.
REQ-002 Parameter TIMEOUT_TICKS, default 1000000, max clk_in cycles between edges before timeout (must be < 2^CNT_W).
REQ-003 Parameter AVG_LOG2, default 0, number of periods averaged = 2^AVG_LOG2 (range 0..4).
REQ-004 clk_in  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, deassertion is sampled on the clk_in rising edge.
REQ-006 sig_in  input  1  asynchronous tick/clock to be measured.
REQ-007 enable  input  1  measurement enable, synchronous to clk_in.
REQ-008 ready  input  1  consumer accepts result when valid && ready.
REQ-009 valid  output  1  result available, held until accepted.
REQ-010 period  output  CNT_W  averaged period in clk_in cycles; 0 on timeout.
REQ-011 timeout  output  1  qualifies current result as timeout (valid with period=0).
REQ-012 overrun  output  1  sticky flag, at least one unaccepted result was overwritten.

Function
REQ-013 sig_in SHALL pass a 2-flop synchronizer, then a registered rising-edge detector; the edge pulse is 1 clk_in cycle, asserted 3 cycles after a sig_in rising edge meeting setup.
REQ-014 FSM states SHALL be IDLE, ARM, MEASURE.
REQ-015 IDLE: counter, accumulator and sample count held at 0; enable=1 -> ARM next cycle.
REQ-016 ARM: waits for the first edge pulse; edge -> MEASURE with counter=1, sample count=0, accumulator=0; no result produced by the arming edge.
REQ-017 MEASURE: counter increments by 1 per cycle; on an edge pulse the counter value (cycles between the two edge pulses) is added to the accumulator, counter reloads to 1, sample count increments.
REQ-018 When sample count reaches 2^AVG_LOG2, the result period = accumulator >> AVG_LOG2 (truncating) SHALL be loaded, valid=1 on the following cycle, and the accumulator and sample count clear; the state stays MEASURE, so consecutive edges keep measuring without re-arming.
REQ-019 The accumulator SHALL be CNT_W+AVG_LOG2 bits; no overflow is possible within TIMEOUT_TICKS.
REQ-020 If the counter reaches TIMEOUT_TICKS in MEASURE or ARM with no edge, the block SHALL load period=0, timeout=1, valid=1, and go to ARM with the counter cleared.
REQ-021 The counter in ARM SHALL count cycles since entry, for timeout only.
REQ-022 Handshake: valid && ready in a cycle -> result consumed; valid deasserts next cycle unless a new result loads in that same cycle, in which case valid stays 1 with new data and overrun is not set.
REQ-023 New result while valid=1 and ready=0: period and timeout SHALL be overwritten and overrun set to 1.
REQ-024 overrun SHALL clear only on a handshake (valid && ready) where no new overwrite occurs in the same cycle.
REQ-025 period and timeout SHALL be stable while valid=1 and no new result loads.
REQ-026 enable=0 in any state -> IDLE next cycle, discarding the partial measurement; valid, period, timeout and overrun are retained until consumed.
REQ-027 Edge pulse and timeout in the same cycle: the edge SHALL win (a normal measurement, no timeout).

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, synchronizer and edge flops=0, counter, accumulator and sample count=0, valid=0, period=0, timeout=0, overrun=0.
REQ-029 Reset mid-measurement SHALL discard all partial data; after release, the first result requires re-arming.

Verification
REQ-030 AVG_LOG2=0, enable=1, sig_in period 10 cycles (5 MHz), ready=1 -> after the arming edge, valid pulses every 10 cycles with period=10, timeout=0.
REQ-031 AVG_LOG2=2, sig_in period 500000 cycles (100 Hz), ready=1 -> one result per 4 periods with period=500000; alternating 9/11-cycle spacing gives period=10.
REQ-032 TIMEOUT_TICKS=1000 with sig_in stuck low after arming -> valid with period=0 and timeout=1 at counter=1000, then ARM; the next two edges yield a normal result.
REQ-033 ready=0 across two results -> second result overwrites the first and overrun=1; ready=1 for one cycle -> valid=0 and overrun=0 next cycle.
REQ-034 rst_n pulsed low mid-MEASURE, and separately enable dropped mid-MEASURE -> all outputs 0 after reset; with enable low, held result retained and no new result until re-armed.
REQ-035 Edge pulse coincident with counter=TIMEOUT_TICKS -> normal result period=TIMEOUT_TICKS, timeout=0.
